sfidante_morra: RTL

Automatic two-player driver for the `MorraCinese` referee: the opposite end of its interface. It produces the referee's inputs (`INIZIO`, `PRIMO`, `SECONDO`) and consumes its outputs (`MANCHE`, `PARTITA`). It plays a complete match using LFSR-generated moves, enforces the no-repeat rule for the previous round winner, tallies the round results and reports the match outcome. It sits beside the referee in the self-test harness and acts as the on-chip stimulus and scoreboard for the game.

---
 rtl/sfidante_morra.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/sfidante_morra.sv
// rtl/sfidante_morra.sv - automatic two-player driver and scoreboard for the MorraCinese referee
// Plays one LFSR-driven match per start request and tallies the referee's round results.
module sfidante_morra #(
  parameter logic [15:0] SEED1 = 16'hACE1,
  parameter logic [15:0] SEED2 = 16'h1D0F
) (
  input  logic       clk,
  input  logic       RESET_N,
  input  logic       AVVIA,
  input  logic [3:0] DURATA,
  input  logic [1:0] MANCHE,
  input  logic [1:0] PARTITA,
  output logic       INIZIO,
  output logic [1:0] PRIMO,
  output logic [1:0] SECONDO,
  output logic [4:0] VINTE1,
  output logic [4:0] VINTE2,
  output logic [4:0] PAREGGI,
  output logic [1:0] ESITO,
  output logic       FINE,
  output logic       OCCUPATO,
  output logic       ERRORE
);

  localparam logic [15:0] INIT1 = (SEED1 == 16'h0000) ? 16'hACE1 : SEED1;
  localparam logic [15:0] INIT2 = (SEED2 == 16'h0000) ? 16'h1D0F : SEED2;

  typedef enum logic [1:0] {S_IDLE, S_AVVIO, S_GIOCO, S_FINE} state_t;

  state_t      state_q, state_d;
  logic        inizio_q, inizio_d;
  logic [1:0]  primo_q, primo_d, secondo_q, secondo_d;
  logic [4:0]  vinte1_q, vinte1_d, vinte2_q, vinte2_d, pareggi_q, pareggi_d;
  logic [1:0]  esito_q, esito_d;
  logic        fine_q, fine_d, occupato_q, occupato_d, errore_q, errore_d;
  logic [15:0] lfsr1_q, lfsr1_d, lfsr2_q, lfsr2_d;
  logic [1:0]  forb1_q, forb1_d, forb2_q, forb2_d;
  logic        lock1_q, lock1_d, lock2_q, lock2_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        end_match;

  function automatic logic [15:0] lfsr_step(input logic [15:0] r);
    return {r[14:0], r[15] ^ r[13] ^ r[12] ^ r[10]};
  endfunction

  // A locked player whose candidate equals its forbidden move takes the next move in the 01-10-11 cycle.
  function automatic logic [1:0] pick_move(input logic [2:0] r, input logic lock,
                                           input logic [1:0] forb);
    logic [1:0] c;
    c = (r[1:0] != 2'b00) ? r[1:0] : {1'b1, r[2]};
    if (lock && (c == forb)) c = (c == 2'b11) ? 2'b01 : c + 2'b01;
    return c;
  endfunction

  function automatic logic [4:0] sat_inc(input logic [4:0] v);
    return (v == 5'd31) ? v : v + 5'd1;
  endfunction

  always_comb begin
    state_d    = state_q;
    inizio_d   = 1'b0;
    primo_d    = primo_q;
    secondo_d  = secondo_q;
    vinte1_d   = vinte1_q;
    vinte2_d   = vinte2_q;
    pareggi_d  = pareggi_q;
    esito_d    = esito_q;
    fine_d     = 1'b0;
    occupato_d = occupato_q;
    errore_d   = errore_q;
    lfsr1_d    = lfsr1_q;
    lfsr2_d    = lfsr2_q;
    forb1_d    = forb1_q;
    forb2_d    = forb2_q;
    lock1_d    = lock1_q;
    lock2_d    = lock2_q;
    cnt_d      = cnt_q;
    end_match  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (AVVIA) begin
          state_d    = S_AVVIO;
          inizio_d   = 1'b1;
          primo_d    = DURATA[3:2];
          secondo_d  = DURATA[1:0];
          occupato_d = 1'b1;
          vinte1_d   = 5'd0;
          vinte2_d   = 5'd0;
          pareggi_d  = 5'd0;
          esito_d    = 2'b00;
          errore_d   = 1'b0;
          lock1_d    = 1'b0;
          lock2_d    = 1'b0;
          cnt_d      = 5'd0;
        end
      end
      S_AVVIO: begin
        state_d   = S_GIOCO;
        primo_d   = pick_move(lfsr1_q[2:0], lock1_q, forb1_q);
        secondo_d = pick_move(lfsr2_q[2:0], lock2_q, forb2_q);
      end
      S_GIOCO: begin
        lfsr1_d = lfsr_step(lfsr1_q);
        lfsr2_d = lfsr_step(lfsr2_q);
        cnt_d   = cnt_q + 5'd1;
        case (MANCHE)
          2'b01: begin
            vinte1_d = sat_inc(vinte1_q);
            forb1_d  = primo_q;
            lock1_d  = 1'b1;
            lock2_d  = 1'b0;
          end
          2'b10: begin
            vinte2_d = sat_inc(vinte2_q);
            forb2_d  = secondo_q;
            lock2_d  = 1'b1;
            lock1_d  = 1'b0;
          end
          2'b11: begin
            pareggi_d = sat_inc(pareggi_q);
            lock1_d   = 1'b0;
            lock2_d   = 1'b0;
          end
          default: begin
            errore_d  = 1'b1;
            esito_d   = 2'b00;
            end_match = 1'b1;
          end
        endcase
        if (MANCHE != 2'b00) begin
          if (PARTITA != 2'b00) begin
            esito_d   = PARTITA;
            end_match = 1'b1;
          end else if (cnt_d == 5'd20) begin
            // The referee caps a match at 19 rounds, so a 20th undecided round means it is stuck.
            errore_d  = 1'b1;
            end_match = 1'b1;
          end
        end
        if (end_match) begin
          state_d    = S_FINE;
          fine_d     = 1'b1;
          primo_d    = 2'b00;
          secondo_d  = 2'b00;
          occupato_d = 1'b0;
        end else begin
          primo_d   = pick_move(lfsr1_d[2:0], lock1_d, forb1_d);
          secondo_d = pick_move(lfsr2_d[2:0], lock2_d, forb2_d);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!RESET_N) begin
      state_q    <= S_IDLE;
      inizio_q   <= 1'b0;
      primo_q    <= 2'b00;
      secondo_q  <= 2'b00;
      vinte1_q   <= 5'd0;
      vinte2_q   <= 5'd0;
      pareggi_q  <= 5'd0;
      esito_q    <= 2'b00;
      fine_q     <= 1'b0;
      occupato_q <= 1'b0;
      errore_q   <= 1'b0;
      lfsr1_q    <= INIT1;
      lfsr2_q    <= INIT2;
      forb1_q    <= 2'b00;
      forb2_q    <= 2'b00;
      lock1_q    <= 1'b0;
      lock2_q    <= 1'b0;
      cnt_q      <= 5'd0;
    end else begin
      state_q    <= state_d;
      inizio_q   <= inizio_d;
      primo_q    <= primo_d;
      secondo_q  <= secondo_d;
      vinte1_q   <= vinte1_d;
      vinte2_q   <= vinte2_d;
      pareggi_q  <= pareggi_d;
      esito_q    <= esito_d;
      fine_q     <= fine_d;
      occupato_q <= occupato_d;
      errore_q   <= errore_d;
      lfsr1_q    <= lfsr1_d;
      lfsr2_q    <= lfsr2_d;
      forb1_q    <= forb1_d;
      forb2_q    <= forb2_d;
      lock1_q    <= lock1_d;
      lock2_q    <= lock2_d;
      cnt_q      <= cnt_d;
    end
  end

  assign INIZIO   = inizio_q;
  assign PRIMO    = primo_q;
  assign SECONDO  = secondo_q;
  assign VINTE1   = vinte1_q;
  assign VINTE2   = vinte2_q;
  assign PAREGGI  = pareggi_q;
  assign ESITO    = esito_q;
  assign FINE     = fine_q;
  assign OCCUPATO = occupato_q;
  assign ERRORE   = errore_q;

endmodule
